lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
- Multi-cycle load/store sequencer between the main decoder and a handshaked data-memory bus.
- Takes memWrite, loadCtrl and storeCtrl from the decoder, plus address and store data from the datapath.
- Issues one bus transaction per memory instruction, stalls the core until it completes, and aligns and extends load data.
- Flags misaligned or illegal accesses, and bus timeouts, without issuing or completing a transaction.

Parameters:
ADDR_WIDTH, 32, width of the byte address and busAddr
TIMEOUT_CYCLES, 255, cycles allowed in REQ+WAIT before busFault; counter width is 8 bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
memRead  input  1  execute-stage instruction is a load (opcode 0000011)
memWrite  input  1  execute-stage instruction is a store (decoder memWrite)
loadCtrl  input  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
storeCtrl  input  2  store funct3[1:0]: 00 SB, 01 SH, 10 SW
address  input  ADDR_WIDTH  byte address from the ALU
storeData  input  32  rs2 value
stall  output  1  freeze PC and execute stage
done  output  1  one-cycle completion pulse
loadWrEn  output  1  write loadData to the register file (done & load & no fault)
loadData  output  32  aligned, extended load result
misaligned  output  1  fault qualifier, valid with done
busFault  output  1  timeout qualifier, valid with done
busReq  output  1  bus request
busWe  output  1  1 = write
busAddr  output  ADDR_WIDTH  word-aligned address, low 2 bits 00
busByteEn  output  4  byte lane enables
busWData  output  32  lane-replicated write data
busReady  input  1  bus accepts the request this cycle
busRValid  input  1  read data valid
busRData  input  32  read data word

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction drops busReq at that edge. busRValid arriving in IDLE is ignored.
- start = memRead | memWrite. If both are set, the access is treated as a store.
- States:
  - IDLE: on start, latch address, ctrl and data, then check legality.
    - Illegal access goes to DONE with misaligned=1 and no bus request. Illegal means: LH/LHU/SH with address[0]=1; LW/SW with address[1:0]≠00; loadCtrl 011/110/111; storeCtrl 11.
    - Legal access goes to REQ.
  - REQ: busReq=1, with busWe, busAddr, busByteEn and busWData held stable.
    - busReady & store goes to DONE.
    - busReady & load goes to WAIT.
  - WAIT: busReq=0. On busRValid, capture the aligned result into loadData and go to DONE.
  - DONE: done=1 for one cycle, stall=0, then go to IDLE.
- stall = (state==IDLE & start) | state==REQ | state==WAIT.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without a completing event, go to DONE with busFault=1.
  - If busReady/busRValid arrives in the same cycle as expiry, the completing event wins.
- Fault handling: on a fault, loadData is held unchanged and loadWrEn=0. misaligned and busFault are registered and valid only while done=1.
- Store lanes (a = address[1:0]):
  - SB: busByteEn = 0001<<a; busWData = {4{storeData[7:0]}}.
  - SH: busByteEn = 0011<<(2*a[1]); busWData = {2{storeData[15:0]}}.
  - SW: busByteEn = 1111; busWData = storeData.
- Loads:
  - busByteEn = 1111.
  - The lane is busRData >> 8*a.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Latency: legal store = 3 cycles (start, REQ, DONE) with zero bus wait. Legal load = 4 cycles if busRValid arrives in the cycle after acceptance. A fault detected in IDLE = 2 cycles.
- Back-to-back memory instructions: the next start is accepted only in IDLE, one cycle after DONE.

Decomposition:
- Shared package lsu_pkg holds: state encoding (IDLE, REQ, WAIT, DONE); load funct3 constants (LB, LH, LW, LBU, LHU); store constants (SB, SH, SW); byte-enable constants.
- Sub-module lsu_align is purely combinational. It handles store byte-enable generation, write-data replication, load lane select and extension, and the legality check.

Test Plan:
- SB, address 0x1003, storeData 0x000000A5, busReady in REQ -> busAddr 0x1000, busByteEn 1000, busWData 0xA5A5A5A5; done in cycle 3; stall high for 2 cycles.
- LB, address 0x2002, busRData 0x00800000 -> loadData 0xFFFFFF80, loadWrEn=1. Same stimulus as LBU -> loadData 0x00000080.
- LW, address 0x3002 -> no busReq; done after 2 cycles with misaligned=1 and loadWrEn=0. Also storeCtrl 11 -> same response.
- LH, address 0x4002, busReady never asserted -> busFault=1 after TIMEOUT_CYCLES; loadData unchanged. Variant with busReady in the expiry cycle -> normal completion.
- LW with busReady delayed 3 cycles, then busRValid 2 cycles later, busRData 0xDEADBEEF -> loadData 0xDEADBEEF; busReq held stable throughout REQ.
- rst_n=0 while in WAIT -> IDLE and busReq=0 at the next edge; a later busRValid produces no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared states, funct3 codes and lane constants for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Load funct3 encodings
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Store funct3[1:0] encodings
    localparam logic [1:0] SD_SB = 2'b00;
    localparam logic [1:0] SD_SH = 2'b01;
    localparam logic [1:0] SD_SW = 2'b10;

    // Byte-enable patterns before shifting into the addressed lane
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Timeout counter width
    localparam int TCNT_W = 8;

    function automatic logic [31:0] extend(input logic [31:0] lane, input logic is_half,
                                           input logic is_signed);
        logic [31:0] r;
        if (is_half) begin
            r = {{16{is_signed & lane[15]}}, lane[15:0]};
        end else begin
            r = {{24{is_signed & lane[7]}}, lane[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational legality check, store lane steering and load extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_load_ctrl,
    input  logic [1:0]  i_store_ctrl,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    output logic        o_legal,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_rsp_load_ctrl,
    input  logic [1:0]  i_rsp_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic [31:0] w_lane;

    // An access is legal when its funct3 is defined and the address is naturally aligned
    always_comb begin
        o_legal = 1'b0;
        if (i_is_store) begin
            case (i_store_ctrl)
                SD_SB:   o_legal = 1'b1;
                SD_SH:   o_legal = ~i_addr_lo[0];
                SD_SW:   o_legal = (i_addr_lo == 2'b00);
                default: o_legal = 1'b0;
            endcase
        end else begin
            case (i_load_ctrl)
                LD_LB, LD_LBU: o_legal = 1'b1;
                LD_LH, LD_LHU: o_legal = ~i_addr_lo[0];
                LD_LW:         o_legal = (i_addr_lo == 2'b00);
                default:       o_legal = 1'b0;
            endcase
        end
    end

    // Stores replicate the datum over every lane so only the byte enables pick the target;
    // loads always fetch the full word
    always_comb begin
        o_byte_en = BE_WORD;
        o_wdata   = i_store_data;
        if (i_is_store) begin
            case (i_store_ctrl)
                SD_SB: begin
                    o_byte_en = BE_BYTE << i_addr_lo;
                    o_wdata   = {4{i_store_data[7:0]}};
                end
                SD_SH: begin
                    o_byte_en = BE_HALF << {i_addr_lo[1], 1'b0};
                    o_wdata   = {2{i_store_data[15:0]}};
                end
                default: begin
                    o_byte_en = BE_WORD;
                    o_wdata   = i_store_data;
                end
            endcase
        end
    end

    assign w_lane = i_rdata >> {i_rsp_addr_lo, 3'b000};

    // Pick the addressed lane of the returned word and sign- or zero-extend it
    always_comb begin
        case (i_rsp_load_ctrl)
            LD_LB:   o_load_data = extend(w_lane, 1'b0, 1'b1);
            LD_LH:   o_load_data = extend(w_lane, 1'b1, 1'b1);
            LD_LBU:  o_load_data = extend(w_lane, 1'b0, 1'b0);
            LD_LHU:  o_load_data = extend(w_lane, 1'b1, 1'b0);
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - multi-cycle load/store sequencer for a handshaked data bus
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [2:0]            loadCtrl,
    input  logic [1:0]            storeCtrl,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           storeData,
    output logic                  stall,
    output logic                  done,
    output logic                  loadWrEn,
    output logic [31:0]           loadData,
    output logic                  misaligned,
    output logic                  busFault,
    output logic                  busReq,
    output logic                  busWe,
    output logic [ADDR_WIDTH-1:0] busAddr,
    output logic [3:0]            busByteEn,
    output logic [31:0]           busWData,
    input  logic                  busReady,
    input  logic                  busRValid,
    input  logic [31:0]           busRData
);

    localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t            r_state;
    logic [TCNT_W-1:0]     r_tcnt;
    logic                  r_is_store;
    logic [2:0]            r_load_ctrl;
    logic [1:0]            r_addr_lo;
    logic                  r_done;
    logic                  r_loadwren;
    logic [31:0]           r_load_data;
    logic                  r_misaligned;
    logic                  r_busfault;
    logic                  r_busreq;
    logic                  r_buswe;
    logic [ADDR_WIDTH-1:0] r_busaddr;
    logic [3:0]            r_busbyteen;
    logic [31:0]           r_buswdata;

    logic                  w_start;
    logic                  w_legal;
    logic                  w_expired;
    logic [3:0]            w_byte_en;
    logic [31:0]           w_wdata;
    logic [31:0]           w_load_result;
    logic [TCNT_W-1:0]     w_tcnt_next;

    assign w_start     = memRead | memWrite;
    // Past the last allowed cycle the counter saturates so a late WAIT entry still expires
    assign w_expired   = (r_tcnt >= TMO_LAST);
    assign w_tcnt_next = (r_tcnt == {TCNT_W{1'b1}}) ? r_tcnt : r_tcnt + 1'b1;

    // Request side uses the live decoder inputs; response side uses what was latched at start
    lsu_align u_align (
        .i_is_store      (memWrite),
        .i_load_ctrl     (loadCtrl),
        .i_store_ctrl    (storeCtrl),
        .i_addr_lo       (address[1:0]),
        .i_store_data    (storeData),
        .o_legal         (w_legal),
        .o_byte_en       (w_byte_en),
        .o_wdata         (w_wdata),
        .i_rsp_load_ctrl (r_load_ctrl),
        .i_rsp_addr_lo   (r_addr_lo),
        .i_rdata         (busRData),
        .o_load_data     (w_load_result)
    );

    // Sequencer: one bus transaction per instruction, outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tcnt       <= '0;
            r_is_store   <= 1'b0;
            r_load_ctrl  <= '0;
            r_addr_lo    <= '0;
            r_done       <= 1'b0;
            r_loadwren   <= 1'b0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_busfault   <= 1'b0;
            r_busreq     <= 1'b0;
            r_buswe      <= 1'b0;
            r_busaddr    <= '0;
            r_busbyteen  <= '0;
            r_buswdata   <= '0;
        end else begin
            r_done       <= 1'b0;
            r_loadwren   <= 1'b0;
            r_misaligned <= 1'b0;
            r_busfault   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_is_store  <= memWrite;
                        r_load_ctrl <= loadCtrl;
                        r_addr_lo   <= address[1:0];
                        if (!w_legal) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state     <= ST_REQ;
                            r_tcnt      <= '0;
                            r_busreq    <= 1'b1;
                            r_buswe     <= memWrite;
                            r_busaddr   <= {address[ADDR_WIDTH-1:2], 2'b00};
                            r_busbyteen <= w_byte_en;
                            r_buswdata  <= memWrite ? w_wdata : 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (busReady) begin
                        r_busreq <= 1'b0;
                        r_tcnt   <= w_tcnt_next;
                        if (r_is_store) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_expired) begin
                        r_busreq   <= 1'b0;
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_busfault <= 1'b1;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                ST_WAIT: begin
                    if (busRValid) begin
                        r_load_data <= w_load_result;
                        r_loadwren  <= 1'b1;
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                    end else if (w_expired) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_busfault <= 1'b1;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall from the very first cycle of a memory instruction until completion
    assign stall = ((r_state == ST_IDLE) & w_start) | (r_state == ST_REQ) | (r_state == ST_WAIT);

    assign done       = r_done;
    assign loadWrEn   = r_loadwren;
    assign loadData   = r_load_data;
    assign misaligned = r_misaligned;
    assign busFault   = r_busfault;
    assign busReq     = r_busreq;
    assign busWe      = r_buswe;
    assign busAddr    = r_busaddr;
    assign busByteEn  = r_busbyteen;
    assign busWData   = r_buswdata;

endmodule

// File: tb/tb_lsu_controller.sv
// tb/tb_lsu_controller.sv - directed and randomized bench with a transaction-level reference model
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead, memWrite;
    logic [2:0]  loadCtrl;
    logic [1:0]  storeCtrl;
    logic [31:0] address, storeData;
    logic        stall, done, loadWrEn, misaligned, busFault;
    logic [31:0] loadData;
    logic        busReq, busWe;
    logic [31:0] busAddr;
    logic [3:0]  busByteEn;
    logic [31:0] busWData;
    logic        busReady, busRValid;
    logic [31:0] busRData;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_ld = 32'd0;

    lsu_controller #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .loadCtrl(loadCtrl), .storeCtrl(storeCtrl), .address(address), .storeData(storeData),
        .stall(stall), .done(done), .loadWrEn(loadWrEn), .loadData(loadData),
        .misaligned(misaligned), .busFault(busFault), .busReq(busReq), .busWe(busWe),
        .busAddr(busAddr), .busByteEn(busByteEn), .busWData(busWData),
        .busReady(busReady), .busRValid(busRValid), .busRData(busRData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; 0 marks an undefined encoding
    function automatic int m_size(input bit st, input logic [2:0] lc, input logic [1:0] sc);
        if (st) return (sc == 2'd3) ? 0 : (1 << sc);
        if (lc == 3'd3 || lc > 3'd5) return 0;
        return 1 << (lc % 4);
    endfunction

    function automatic logic [3:0] m_be(input int size, input logic [1:0] a);
        int v;
        v = ((1 << size) - 1) << a;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wd(input int size, input logic [31:0] sd);
        longint v, w;
        v = longint'(sd) & ((64'd1 << (8 * size)) - 1);
        w = 0;
        for (int k = 0; k < 4 / size; k++) w = w | (v << (8 * size * k));
        return 32'(w);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] lc, input logic [1:0] a,
                                           input logic [31:0] rd);
        longint v;
        int size;
        size = m_size(1'b0, lc, 2'd0);
        v = (longint'(rd) >> (8 * a)) & ((64'd1 << (8 * size)) - 1);
        if (lc < 3'd4 && size < 4 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
        return 32'(v);
    endfunction

    // rdy/rv: number of REQ/WAIT cycles before busReady/busRValid (-1 = never)
    task automatic run_op(input string tag, input bit rd, input bit wr, input logic [2:0] lc,
                          input logic [1:0] sc, input logic [31:0] addr, input logic [31:0] sd,
                          input int rdy, input int rv, input logic [31:0] rdat);
        bit st, legal, ok, accepted, seen_req, unstable, got_done;
        int size, exp_cyc, dl, cyc, stall_cnt, i_req, i_wait;
        logic [3:0] be0;
        logic [31:0] a0, wd0;
        st    = wr;
        size  = m_size(st, lc, sc);
        legal = (size != 0) && ((addr % size) == 0);
        ok    = 1'b0;
        if (!legal) begin
            exp_cyc = 2;
        end else if (st) begin
            ok      = (rdy >= 0 && rdy <= 254);
            exp_cyc = ok ? rdy + 3 : 257;
        end else if (!(rdy >= 0 && rdy <= 254)) begin
            exp_cyc = 257;
        end else begin
            dl = (rdy + 1 > 254) ? rdy + 1 : 254;
            ok = (rv >= 0 && rdy + 1 + rv <= dl);
            exp_cyc = ok ? rdy + rv + 4 : dl + 3;
        end

        @(negedge clk);
        memRead = rd; memWrite = wr; loadCtrl = lc; storeCtrl = sc;
        address = addr; storeData = sd;
        #1;
        chk({tag, ".stall_start"}, 32'(stall), 32'd1);
        stall_cnt = 1; cyc = 1; i_req = 0; i_wait = 0;
        accepted = 0; seen_req = 0; unstable = 0; got_done = 0;
        be0 = '0; a0 = '0; wd0 = '0;
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            memRead = 0; memWrite = 0; busReady = 0; busRValid = 0; busRData = $urandom;
            if (done) begin
                got_done = 1;
            end else begin
                if (stall) stall_cnt++;
                if (busReq) begin
                    if (!seen_req) begin
                        seen_req = 1; a0 = busAddr; be0 = busByteEn; wd0 = busWData;
                        chk({tag, ".busWe"}, 32'(busWe), 32'(st));
                        chk({tag, ".busAddr"}, busAddr, addr & ~32'd3);
                        chk({tag, ".busByteEn"}, 32'(busByteEn), st ? 32'(m_be(size, addr[1:0])) : 32'hF);
                        if (st) chk({tag, ".busWData"}, busWData, m_wd(size, sd));
                    end else if (busAddr !== a0 || busByteEn !== be0 || busWData !== wd0) begin
                        unstable = 1;
                    end
                    if (i_req == rdy) begin busReady = 1; accepted = 1; end
                    i_req++;
                end else if (accepted) begin
                    if (i_wait == rv) begin busRValid = 1; busRData = rdat; end
                    i_wait++;
                end
            end
        end
        chk({tag, ".done_seen"}, 32'(got_done), 32'd1);
        chk({tag, ".cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_cyc - 1));
        chk({tag, ".stall_at_done"}, 32'(stall), 32'd0);
        chk({tag, ".misaligned"}, 32'(misaligned), 32'(!legal));
        chk({tag, ".busFault"}, 32'(busFault), 32'(legal && !ok));
        chk({tag, ".loadWrEn"}, 32'(loadWrEn), 32'(!st && ok));
        chk({tag, ".bus_issued"}, 32'(seen_req), 32'(legal));
        if (seen_req) chk({tag, ".req_stable"}, 32'(unstable), 32'd0);
        if (!st && ok) exp_ld = m_load(lc, addr[1:0], rdat);
        chk({tag, ".loadData"}, loadData, exp_ld);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle_busReq"}, 32'(busReq), 32'd0);
    endtask

    initial begin
        rst_n = 0; memRead = 0; memWrite = 0; loadCtrl = 0; storeCtrl = 0;
        address = 0; storeData = 0; busReady = 0; busRValid = 0; busRData = 0;
        repeat (3) @(negedge clk);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.busReq", 32'(busReq), 32'd0);
        chk("rst.busByteEn", 32'(busByteEn), 32'd0);
        chk("rst.busAddr", busAddr, 32'd0);
        chk("rst.loadData", loadData, 32'd0);
        rst_n = 1;

        run_op("sb_1003", 0, 1, 3'd0, 2'b00, 32'h1003, 32'h000000A5, 0, 0, 0);
        chk("sb_1003.ref_be", 32'(m_be(1, 2'd3)), 32'h8);
        run_op("lb_2002", 1, 0, 3'b000, 2'd0, 32'h2002, 0, 0, 0, 32'h00800000);
        chk("lb_2002.value", loadData, 32'hFFFFFF80);
        run_op("lbu_2002", 1, 0, 3'b100, 2'd0, 32'h2002, 0, 0, 0, 32'h00800000);
        chk("lbu_2002.value", loadData, 32'h00000080);
        run_op("lw_misal", 1, 0, 3'b010, 2'd0, 32'h3002, 0, 0, 0, 32'h12345678);
        run_op("sc11", 0, 1, 3'd0, 2'b11, 32'h3000, 32'h55, 0, 0, 0);
        run_op("lc011", 1, 0, 3'b011, 2'd0, 32'h3000, 0, 0, 0, 32'h1);
        run_op("lh_tmo", 1, 0, 3'b001, 2'd0, 32'h4002, 0, -1, 0, 32'h7777);
        run_op("lh_edge", 1, 0, 3'b001, 2'd0, 32'h4002, 0, 254, 0, 32'h80010000);
        run_op("lhu_4002", 1, 0, 3'b101, 2'd0, 32'h4002, 0, 1, 0, 32'h80010000);
        run_op("sw_tmo", 0, 1, 3'd0, 2'b10, 32'h5000, 32'hCAFEF00D, -1, 0, 0);
        run_op("sh_edge", 0, 1, 3'd0, 2'b01, 32'h5002, 32'h1234BEEF, 254, 0, 0);
        run_op("lw_late_rv", 1, 0, 3'b010, 2'd0, 32'h5004, 0, 250, 10, 32'h1);
        run_op("lw_dly", 1, 0, 3'b010, 2'd0, 32'h3000, 0, 3, 1, 32'hDEADBEEF);
        chk("lw_dly.value", loadData, 32'hDEADBEEF);
        run_op("both_sw", 1, 1, 3'b000, 2'b10, 32'h6000, 32'h0BADF00D, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 5);
            run_op($sformatf("rnd%0d", n), mode != 1, mode >= 1 && mode <= 2,
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Reset while the request is outstanding drops busReq at that edge
        @(negedge clk);
        memRead = 1; loadCtrl = 3'b010; address = 32'h7000;
        @(negedge clk);
        memRead = 0;
        chk("rstreq.busReq_before", 32'(busReq), 32'd1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rstreq.busReq", 32'(busReq), 32'd0);
        chk("rstreq.stall", 32'(stall), 32'd0);

        // Reset while waiting for data; the late read data must not complete anything
        @(negedge clk);
        memRead = 1; loadCtrl = 3'b010; address = 32'h7000;
        @(negedge clk);
        memRead = 0; busReady = 1;
        @(negedge clk);
        busReady = 0;
        chk("rstwait.in_wait", 32'({stall, busReq}), 32'b10);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        exp_ld = 32'd0;
        chk("rstwait.busReq", 32'(busReq), 32'd0);
        chk("rstwait.stall", 32'(stall), 32'd0);
        chk("rstwait.loadData", loadData, exp_ld);
        busRValid = 1; busRData = 32'hFFFFFFFF;
        @(negedge clk);
        busRValid = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstwait.no_done%0d", k), 32'({done, loadWrEn}), 32'd0);
            @(negedge clk);
        end
        chk("rstwait.loadData_after", loadData, exp_ld);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
